// File: rtl/mp_add_pkg.sv
// Shared definitions for the multi-precision add scheduler.
package mp_add_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  // Carry into the next word from the adder's group generate/propagate.
  function automatic logic cla_carry(input logic g, input logic p, input logic c);
    return g | (p & c);
  endfunction

endpackage

// File: rtl/mp_add_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            any
);

  int cand;

  // Scan requesters starting at ptr, wrapping, and take the first one asserted.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = (int'(ptr) + k) % NREQ;
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/s16bit.sv
// 16-bit carry-lookahead adder built from four 4-bit groups.
// Exposes group generate/propagate so callers can chain words externally.
module s16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] s,
  output logic        g,
  output logic        p
);

  logic [15:0] gi;
  logic [15:0] pi;
  logic [3:0]  gg;
  logic [3:0]  gp;
  logic [3:0]  cn;
  logic        cc;

  // Bit and group generate/propagate, lookahead carries into each nibble, sums.
  always_comb begin
    gi = a & b;
    pi = a ^ b;
    gg = '0;
    gp = '0;
    cn = '0;
    s  = '0;
    cc = 1'b0;
    for (int j = 0; j < 4; j++) begin
      for (int k = 0; k < 4; k++) begin
        gg[j] = gi[4*j+k] | (pi[4*j+k] & gg[j]);
      end
      gp[j] = &pi[4*j +: 4];
    end
    cn[0] = cin;
    for (int j = 0; j < 3; j++) begin
      cn[j+1] = gg[j] | (gp[j] & cn[j]);
    end
    for (int j = 0; j < 4; j++) begin
      cc = cn[j];
      for (int k = 0; k < 4; k++) begin
        s[4*j+k] = pi[4*j+k] ^ cc;
        cc       = gi[4*j+k] | (pi[4*j+k] & cc);
      end
    end
    g = gg[3] | (gp[3] & (gg[2] | (gp[2] & (gg[1] | (gp[1] & gg[0])))));
    p = &gp;
  end

endmodule

// File: rtl/mp_add_sched.sv
// Round-robin scheduler sharing one s16bit adder among NREQ requesters.
// Each grant runs a WORDS x 16-bit add, one word per cycle, LSW first.
// Optional subtract support is enabled with the MPADD_SUB_EN macro.
//
// Handshake: a requester holds req high with stable operands until it is
// granted; operands are latched on the grant and later req/operand changes
// are ignored. done pulses for one cycle with sum/cout/done_id valid; the
// requester must drop req in the cycle after done or it is re-arbitrated.
module mp_add_sched
  import mp_add_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int WORDS = 4
) (
  input  logic                      clk,
  input  logic                      nrst,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*WORD_W*WORDS-1:0] req_a,
  input  logic [NREQ*WORD_W*WORDS-1:0] req_b,
  input  logic [NREQ-1:0]           req_cin,
`ifdef MPADD_SUB_EN
  input  logic [NREQ-1:0]           req_sub,
`endif
  output logic [NREQ-1:0]           gnt,
  output logic                      busy,
  output logic                      done,
  output logic [$clog2(NREQ)-1:0]   done_id,
  output logic [WORD_W*WORDS-1:0]   sum,
  output logic                      cout
);

  localparam int N  = WORD_W * WORDS;
  localparam int IW = $clog2(NREQ);
  localparam int WW = (WORDS > 1) ? $clog2(WORDS) : 1;

  state_t          state;
  state_t          state_next;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   id;
  logic [WW-1:0]   widx;
  logic [N-1:0]    work_a;
  logic [N-1:0]    work_b;
  logic [N-1:0]    work_sum;
  logic            c;
  logic            sub_q;

  logic [NREQ-1:0] arb_gnt;
  logic [IW-1:0]   arb_idx;
  logic            arb_any;

  logic [15:0]     add_b;
  logic [15:0]     add_s;
  logic            add_g;
  logic            add_p;
  logic            c_next;
  logic [N-1:0]    sum_next;
  logic            last_word;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req (req),
    .ptr (rr_ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  // Work operands shift right one word per RUN cycle, so the adder always sees word 0.
  assign add_b = work_b[WORD_W-1:0] ^ {WORD_W{sub_q}};

  s16bit u_add (
    .a   (work_a[WORD_W-1:0]),
    .b   (add_b),
    .cin (c),
    .s   (add_s),
    .g   (add_g),
    .p   (add_p)
  );

  assign c_next    = cla_carry(add_g, add_p, c);
  // New word enters at the top; after WORDS cycles the LSW has reached bit 0.
  assign sum_next  = (work_sum >> WORD_W) | (N'(add_s) << (N - WORD_W));
  assign last_word = (widx == WW'(WORDS - 1));
  assign busy      = (state != S_IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (!nrst) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (arb_any)   state_next = S_RUN;
      S_RUN:   if (last_word) state_next = S_DONE;
      S_DONE:                 state_next = S_IDLE;
      default:                state_next = S_IDLE;
    endcase
  end

  // Latch operands on grant, step one word per RUN cycle, publish the result into DONE.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      rr_ptr   <= '0;
      id       <= '0;
      widx     <= '0;
      work_a   <= '0;
      work_b   <= '0;
      work_sum <= '0;
      c        <= 1'b0;
      sub_q    <= 1'b0;
      gnt      <= '0;
      done     <= 1'b0;
      done_id  <= '0;
      sum      <= '0;
      cout     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (arb_any) begin
            work_a   <= req_a[arb_idx*N +: N];
            work_b   <= req_b[arb_idx*N +: N];
            work_sum <= '0;
`ifdef MPADD_SUB_EN
            sub_q    <= req_sub[arb_idx];
            c        <= req_sub[arb_idx] | req_cin[arb_idx];
            if (req_sub[arb_idx]) c <= 1'b1;
            else                  c <= req_cin[arb_idx];
`else
            sub_q    <= 1'b0;
            c        <= req_cin[arb_idx];
`endif
            gnt      <= arb_gnt;
            id       <= arb_idx;
            widx     <= '0;
          end
        end
        S_RUN: begin
          work_a   <= work_a >> WORD_W;
          work_b   <= work_b >> WORD_W;
          work_sum <= sum_next;
          c        <= c_next;
          widx     <= widx + 1'b1;
          if (last_word) begin
            sum     <= sum_next;
            cout    <= c_next;
            done    <= 1'b1;
            done_id <= id;
          end
        end
        S_DONE: begin
          done   <= 1'b0;
          gnt    <= '0;
          rr_ptr <= (id == IW'(NREQ - 1)) ? '0 : id + 1'b1;
        end
        default: begin
          done <= 1'b0;
          gnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mp_add_sched.sv
// Self-checking bench for mp_add_sched (NREQ=2, WORDS=4).
// Define MPADD_SUB_EN to also exercise the subtract path.
module tb_mp_add_sched;

  localparam int NREQ  = 2;
  localparam int WORDS = 4;
  localparam int N     = 16 * WORDS;
  localparam int W     = N + 2;   // {id, cout, sum}

  logic              clk = 1'b0;
  logic              nrst = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*N-1:0] req_a = '0;
  logic [NREQ*N-1:0] req_b = '0;
  logic [NREQ-1:0]   req_cin = '0;
`ifdef MPADD_SUB_EN
  logic [NREQ-1:0]   req_sub = '0;
`endif
  logic [NREQ-1:0]   gnt;
  logic              busy;
  logic              done;
  logic [0:0]        done_id;
  logic [N-1:0]      sum;
  logic              cout;

  mp_add_sched #(.NREQ(NREQ), .WORDS(WORDS)) dut (
    .clk     (clk),
    .nrst    (nrst),
    .req     (req),
    .req_a   (req_a),
    .req_b   (req_b),
    .req_cin (req_cin),
`ifdef MPADD_SUB_EN
    .req_sub (req_sub),
`endif
    .gnt     (gnt),
    .busy    (busy),
    .done    (done),
    .done_id (done_id),
    .sum     (sum),
    .cout    (cout)
  );

  // Clock / cycle counter / watchdog
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard state
  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_fail = 0;
  int model_ptr = 0;
  logic mon_en = 1'b0;

  logic [N-1:0] op_a[NREQ];
  logic [N-1:0] op_b[NREQ];
  logic         op_cin[NREQ];
  logic         op_sub[NREQ];

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Reference: full-width arithmetic on the whole operand.
  function automatic logic [W-1:0] model(input int i, input logic [N-1:0] a, input logic [N-1:0] b,
                                         input logic cin, input logic sub);
    logic [N:0]   r;
    logic [N-1:0] bb;
    logic         ci;
    logic [31:0]  iv;
    bb = sub ? ~b : b;
    ci = sub ? 1'b1 : cin;
    r  = {1'b0, a} + {1'b0, bb} + {{N{1'b0}}, ci};
    iv = i;
    return {iv[0], r};
  endfunction

  // Monitor: pops expected results whenever done is presented
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (mon_en) begin
      check("gnt_onehot0", {127'd0, $onehot0(gnt)}, 128'd1);
      if (done) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_done: got done_id %0d sum 0x%0h want no done (cycle %0d)", done_id, sum, cyc);
        end else begin
          e = exp_q.pop_front();
          check("done_id", {127'd0, done_id}, {127'd0, e[W-1]});
          check("cout", {127'd0, cout}, {127'd0, e[N]});
          check("sum", {64'd0, sum}, {64'd0, e[N-1:0]});
          check("gnt_at_done", {126'd0, gnt}, {126'd0, (2'b01 << e[W-1])});
        end
      end
    end
  end

  // Driver tasks
  task automatic set_op(input int i, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic cin, input logic sub);
    op_a[i]   = a;
    op_b[i]   = b;
    op_cin[i] = cin;
`ifdef MPADD_SUB_EN
    op_sub[i] = sub;
    req_sub[i] = sub;
`else
    op_sub[i] = 1'b0;
`endif
    req_a[i*N +: N] = a;
    req_b[i*N +: N] = b;
    req_cin[i]      = cin;
  endtask

  // Raise the masked requests together, drop each after its done.
  task automatic run_batch(input logic [NREQ-1:0] mask, output int lat);
    int last;
    int idx;
    int t0;
    int waited;
    last = model_ptr;
    for (int k = 0; k < NREQ; k++) begin
      idx = (model_ptr + k) % NREQ;
      if (mask[idx]) begin
        exp_q.push_back(model(idx, op_a[idx], op_b[idx], op_cin[idx], op_sub[idx]));
        last = idx;
      end
    end
    model_ptr = (last + 1) % NREQ;
    @(negedge clk);
    req    = mask;
    t0     = cyc;
    lat    = -1;
    waited = 0;
    while (req != '0 && waited < 100) begin
      @(negedge clk);
      waited++;
      if (done) begin
        if (lat < 0) lat = cyc - t0;
        req[done_id] = 1'b0;
      end
    end
    if (req != '0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL batch_timeout: got req still 0x%0h after %0d cycles want 0", req, waited);
      req = '0;
    end
    @(negedge clk);
  endtask

  // Hold every request high for n operations; grants must alternate.
  task automatic run_held(input int n);
    int got;
    int prev;
    int waited;
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(model(model_ptr, op_a[model_ptr], op_b[model_ptr],
                            op_cin[model_ptr], op_sub[model_ptr]));
      model_ptr = (model_ptr + 1) % NREQ;
    end
    @(negedge clk);
    req    = '1;
    got    = 0;
    prev   = 0;
    waited = 0;
    while (got < n && waited < 200) begin
      @(negedge clk);
      waited++;
      if (done) begin
        got++;
        if (got > 1) check("held_period", 128'(cyc - prev), 128'(WORDS + 2));
        prev = cyc;
        if (got == n) req = '0;
      end
    end
    if (got < n) begin
      n_cmp++;
      n_fail++;
      $display("FAIL held_timeout: got %0d dones want %0d", got, n);
    end
    req = '0;
    @(negedge clk);
  endtask

  // Main sequence
  initial begin
    int lat;
    logic [NREQ-1:0] mask;
    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = '0; op_b[i] = '0; op_cin[i] = 1'b0; op_sub[i] = 1'b0;
    end

    // Reset state
    nrst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_gnt", {126'd0, gnt}, 128'd0);
    check("rst_busy", {127'd0, busy}, 128'd0);
    check("rst_done", {127'd0, done}, 128'd0);
    check("rst_done_id", {127'd0, done_id}, 128'd0);
    check("rst_sum", {64'd0, sum}, 128'd0);
    check("rst_cout", {127'd0, cout}, 128'd0);
    nrst   = 1'b1;
    mon_en = 1'b1;

    // Carry ripples from word 0 into word 3
    set_op(0, 64'h0000FFFFFFFFFFFF, 64'd1, 1'b0, 1'b0);
    run_batch(2'b01, lat);
    check("latency", 128'(lat), 128'(WORDS + 1));
    check("t1_sum_hold", {64'd0, sum}, {64'd0, 64'h0001000000000000});

    // Carry-in propagates through all words
    set_op(1, 64'hFFFFFFFFFFFFFFFF, 64'd0, 1'b1, 1'b0);
    run_batch(2'b10, lat);
    check("t2_sum_hold", {64'd0, sum}, 128'd0);
    check("t2_cout_hold", {127'd0, cout}, 128'd1);

    // Simultaneous requests served in pointer order
    set_op(0, {$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'b0, 1'b0);
    set_op(1, {$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'b1, 1'b0);
    run_batch(2'b11, lat);

    // Continuous requests alternate
    run_held(4);

    // Synchronous abort at widx=2
    set_op(0, {$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'b1, 1'b0);
    @(negedge clk);
    req = 2'b01;
    repeat (3) @(negedge clk);
    check("busy_in_run", {127'd0, busy}, 128'd1);
    nrst = 1'b0;
    req  = '0;
    @(negedge clk);
    check("abort_gnt", {126'd0, gnt}, 128'd0);
    check("abort_busy", {127'd0, busy}, 128'd0);
    check("abort_sum", {64'd0, sum}, 128'd0);
    nrst = 1'b1;
    model_ptr = 0;
    repeat (12) @(negedge clk);
    set_op(1, {$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'b0, 1'b0);
    run_batch(2'b10, lat);
    check("post_abort_latency", 128'(lat), 128'(WORDS + 1));

`ifdef MPADD_SUB_EN
    // Subtract: borrow signalled by cout=0
    set_op(0, 64'd5, 64'd7, 1'b0, 1'b1);
    run_batch(2'b01, lat);
    check("sub_neg_sum", {64'd0, sum}, {64'd0, 64'hFFFFFFFFFFFFFFFE});
    check("sub_neg_cout", {127'd0, cout}, 128'd0);
    set_op(0, 64'd7, 64'd5, 1'b1, 1'b1);
    run_batch(2'b01, lat);
    check("sub_pos_sum", {64'd0, sum}, 128'd2);
    check("sub_pos_cout", {127'd0, cout}, 128'd1);
`endif

    // Randomized batches
    for (int t = 0; t < 25; t++) begin
      mask = 2'($urandom_range(1, 3));
      for (int i = 0; i < NREQ; i++) begin
        logic [N-1:0] a;
        logic [N-1:0] b;
        a = {$urandom(), $urandom()};
        b = {$urandom(), $urandom()};
        if ($urandom_range(0, 4) == 0) a = '1;
        if ($urandom_range(0, 4) == 0) b = '0;
        set_op(i, a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      run_batch(mask, lat);
    end

    repeat (4) @(negedge clk);
    check("leftover_expected", 128'(exp_q.size()), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
